// File: rtl/uart_rx.sv
// UART receiver: oversampled start detect, LSB-first data, stop check, valid/ack handshake.
// Optional parity bit before the stop bit when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int SIZE       = 8,
  parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic            CLK,
  input  logic            R,
  input  logic            RXC_EN,
  input  logic            RXD,
  output logic [SIZE-1:0] RXDATA,
  output logic            RX_VALID,
  input  logic            RX_ACK,
  output logic            RX_BUSY,
  output logic            FRAME_ERR,
  output logic            OVERRUN
`ifdef UART_RX_PARITY_EN
  ,
  output logic            PARITY_ERR
`endif
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state_q, state_d;
  logic            rx_meta_q, rxs_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [SIZE-1:0] shift_q, shift_d;
  logic [SIZE-1:0] rxdata_q, rxdata_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            deliver;
`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d;
  logic            perr_q, perr_d;
`endif

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge CLK) begin
    if (R) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= RXD;
      rxs_q     <= rx_meta_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    rxdata_d = rxdata_q;
    valid_d  = valid_q;
    ferr_d   = ferr_q;
    ovr_d    = ovr_q;
    deliver  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d    = par_q;
    perr_d   = perr_q;
`endif

    if (RXC_EN) begin
      case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            state_d = S_START;
            cnt_d   = '0;
          end
        end
        S_START: begin
          if (cnt_q == CNT_MID) begin
            if (rxs_q) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
              cnt_d   = '0;
              idx_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // From here on cnt_q == 0 marks mid-bit, so a full period lands mid-bit again.
        S_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d          = '0;
            shift_d[idx_q] = rxs_q;
            if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PAR;
`else
              state_d = S_STOP;
`endif
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PAR: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            par_d   = rxs_q;
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            deliver = 1'b1;
            state_d = rxs_q ? S_IDLE : S_BREAK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_BREAK: begin
          if (rxs_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (valid_q && RX_ACK) valid_d = 1'b0;

    // A delivery wins over a same-edge ack; it only counts as lost if nobody acked.
    if (deliver) begin
      rxdata_d = shift_q;
      valid_d  = 1'b1;
      ferr_d   = ~rxs_q;
      if (valid_q && !RX_ACK) ovr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
      perr_d   = ((^shift_q) ^ par_q) != PARITY_ODD;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      state_q  <= S_IDLE;
      rxdata_q <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rxdata_q <= rxdata_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
`ifdef UART_RX_PARITY_EN
      perr_q   <= perr_d;
`endif
    end
  end

  // Datapath registers are always re-initialised by the FSM before use.
  always_ff @(posedge CLK) begin
    cnt_q   <= cnt_d;
    idx_q   <= idx_d;
    shift_q <= shift_d;
`ifdef UART_RX_PARITY_EN
    par_q   <= par_d;
`endif
  end

  assign RXDATA    = rxdata_q;
  assign RX_VALID  = valid_q;
  assign RX_BUSY   = (state_q != S_IDLE);
  assign FRAME_ERR = ferr_q;
  assign OVERRUN   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign PARITY_ERR = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected words, a monitor pops on delivery.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       R, RXC_EN, RXD, RX_ACK;
  logic [7:0] RXDATA;
  logic       RX_VALID, RX_BUSY, FRAME_ERR, OVERRUN;
`ifdef UART_RX_PARITY_EN
  logic       PARITY_ERR;
  logic       par_flip = 1'b0;
  localparam int STOP_EDGE = 171;
`else
  localparam int STOP_EDGE = 155;
`endif

  always #5 CLK = ~CLK;

  uart_rx dut (
    .CLK      (CLK),
    .R        (R),
    .RXC_EN   (RXC_EN),
    .RXD      (RXD),
    .RXDATA   (RXDATA),
    .RX_VALID (RX_VALID),
    .RX_ACK   (RX_ACK),
    .RX_BUSY  (RX_BUSY),
    .FRAME_ERR(FRAME_ERR),
`ifdef UART_RX_PARITY_EN
    .PARITY_ERR(PARITY_ERR),
`endif
    .OVERRUN  (OVERRUN)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       ovr;
    logic       pe;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_per_bit = 16;
  bit   half_rate = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic fe, input logic ovr, input logic pe);
    exp_t e;
    e.d = d; e.fe = fe; e.ovr = ovr; e.pe = pe;
    expq.push_back(e);
  endtask

  task automatic tick_gen();
    forever begin
      @(posedge CLK);
      #1 RXC_EN = half_rate ? ~RXC_EN : 1'b1;
    end
  endtask

  // New word = valid rising, or a changed word while valid stays high.
  task automatic monitor();
    logic       pv = 1'b0;
    logic [7:0] pd = '0;
    logic       pf = 1'b0;
    exp_t       e;
    forever begin
      @(negedge CLK);
      if (RX_VALID && (!pv || RXDATA !== pd || FRAME_ERR !== pf)) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%0h required=none", RXDATA);
        end else begin
          e = expq.pop_front();
          chk("rxdata", {24'd0, RXDATA}, {24'd0, e.d});
          chk("frame_err", {31'd0, FRAME_ERR}, {31'd0, e.fe});
          chk("overrun", {31'd0, OVERRUN}, {31'd0, e.ovr});
`ifdef UART_RX_PARITY_EN
          chk("parity_err", {31'd0, PARITY_ERR}, {31'd0, e.pe});
`endif
        end
      end
      pv = RX_VALID;
      pd = RXDATA;
      pf = FRAME_ERR;
    end
  endtask

  // Start bit driven just after edge E0; each bit lasts cyc_per_bit cycles.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    @(posedge CLK);
    #1 RXD = 1'b0;
    repeat (cyc_per_bit) @(posedge CLK);
    for (int i = 0; i < 8; i++) begin
      #1 RXD = d[i];
      repeat (cyc_per_bit) @(posedge CLK);
    end
`ifdef UART_RX_PARITY_EN
    #1 RXD = (^d) ^ par_flip;
    repeat (cyc_per_bit) @(posedge CLK);
`endif
    #1 RXD = stop_bit;
    repeat (cyc_per_bit) @(posedge CLK);
    if (stop_bit) #1 RXD = 1'b1;
  endtask

  task automatic wait_valid_ack();
    int n = 0;
    while (RX_VALID !== 1'b1 && n < 800) begin
      @(negedge CLK);
      n++;
    end
    chk("valid_held", {31'd0, RX_VALID}, 32'd1);
    @(posedge CLK);
    #1 RX_ACK = 1'b1;
    @(posedge CLK);
    #1 RX_ACK = 1'b0;
    chk("valid_after_ack", {31'd0, RX_VALID}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge CLK);
    #1 R = 1'b1;
    @(posedge CLK);
    #1 R = 1'b0;
  endtask

  initial begin
    R = 1'b1; RXC_EN = 1'b1; RXD = 1'b1; RX_ACK = 1'b0;
    fork
      monitor();
      tick_gen();
    join_none
    repeat (3) @(posedge CLK);
    #1 R = 1'b0;

    // Idle line after reset
    repeat (500) @(posedge CLK);
    #1;
    chk("idle_valid", {31'd0, RX_VALID}, 32'd0);
    chk("idle_busy", {31'd0, RX_BUSY}, 32'd0);
    chk("idle_ferr", {31'd0, FRAME_ERR}, 32'd0);
    chk("idle_ovr", {31'd0, OVERRUN}, 32'd0);
    chk("idle_data", {24'd0, RXDATA}, 32'd0);

    // Basic word
    push(8'hA5, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1);
    repeat (5) @(posedge CLK);
    #1 chk("a5_valid_hold", {31'd0, RX_VALID}, 32'd1);
    wait_valid_ack();

    // Start glitch of 4 ticks
    @(posedge CLK);
    #1 RXD = 1'b0;
    repeat (4) @(posedge CLK);
    #1 RXD = 1'b1;
    chk("glitch_busy", {31'd0, RX_BUSY}, 32'd1);
    repeat (20) @(posedge CLK);
    #1;
    chk("glitch_idle", {31'd0, RX_BUSY}, 32'd0);
    chk("glitch_valid", {31'd0, RX_VALID}, 32'd0);

    // Framing error followed by a held-low line, then a good word
    push(8'h3C, 1'b1, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0);
    wait_valid_ack();
    repeat (40 * 16) @(posedge CLK);
    #1;
    chk("break_busy", {31'd0, RX_BUSY}, 32'd1);
    chk("break_valid", {31'd0, RX_VALID}, 32'd0);
    RXD = 1'b1;
    repeat (32) @(posedge CLK);
    #1 chk("break_exit", {31'd0, RX_BUSY}, 32'd0);
    push(8'h81, 1'b0, 1'b0, 1'b0);
    send_frame(8'h81, 1'b1);
    wait_valid_ack();

    // Overrun: second word without ack
    push(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h11, 1'b1);
    push(8'h22, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1);
    #1;
    chk("ovr_set", {31'd0, OVERRUN}, 32'd1);
    chk("ovr_data", {24'd0, RXDATA}, 32'h22);
    pulse_reset();
    chk("ovr_cleared", {31'd0, OVERRUN}, 32'd0);

    // Ack on the very edge that delivers the second word
    push(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h11, 1'b1);
    push(8'h22, 1'b0, 1'b0, 1'b0);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (STOP_EDGE) @(posedge CLK);
        #1 RX_ACK = 1'b1;
        @(posedge CLK);
        #1 RX_ACK = 1'b0;
      end
    join
    #1;
    chk("ack_edge_ovr", {31'd0, OVERRUN}, 32'd0);
    chk("ack_edge_valid", {31'd0, RX_VALID}, 32'd1);

    // Reset in the middle of data bit 4 (word 0x22 still pending)
    @(posedge CLK);
    #1 RXD = 1'b0;
    repeat (16 * 5 + 8) @(posedge CLK);
    #1 chk("busy_before_reset", {31'd0, RX_BUSY}, 32'd1);
    R = 1'b1;
    RXD = 1'b1;
    @(posedge CLK);
    #1 R = 1'b0;
    chk("rst_valid", {31'd0, RX_VALID}, 32'd0);
    chk("rst_busy", {31'd0, RX_BUSY}, 32'd0);
    chk("rst_data", {24'd0, RXDATA}, 32'd0);
    chk("rst_ovr", {31'd0, OVERRUN}, 32'd0);
    repeat (32) @(posedge CLK);
    push(8'h7E, 1'b0, 1'b0, 1'b0);
    send_frame(8'h7E, 1'b1);
    wait_valid_ack();

    // Tick enable every other cycle: counters must hold on idle cycles
    half_rate = 1'b1;
    cyc_per_bit = 32;
    repeat (4) @(posedge CLK);
    push(8'hC3, 1'b0, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b1);
    wait_valid_ack();
    half_rate = 1'b0;
    cyc_per_bit = 16;
    repeat (4) @(posedge CLK);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight; a 0 parity bit is wrong for even parity
    par_flip = 1'b1;
    push(8'h07, 1'b0, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1);
    wait_valid_ack();
    par_flip = 1'b0;
`endif

    repeat (10) @(posedge CLK);
    chk("queue_empty", expq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the downstream counterpart of the TX serializer. Consumes the serial line TXD drives, through an external link or an on-chip loopback.
- Oversamples RXD on a tick enable, detects the start bit and shifts in SIZE data bits LSB first. Checks the stop bit and presents a parallel word with a valid/ack handshake.
- Frame format matches TX: start 0, data LSB first, stop 1.

Parameters:
SIZE, 8, data bits per frame
OVERSAMPLE, 16, RXC_EN ticks per bit period; even, >= 4

Ports:
CLK  in  1  system clock
R  in  1  synchronous active-high reset
RXC_EN  in  1  oversample tick, one-cycle pulse at OVERSAMPLE x baud
RXD  in  1  asynchronous serial input, idle high
RXDATA  out  SIZE  received word
RX_VALID  out  1  RXDATA holds an unacknowledged word
RX_ACK  in  1  consumer accepts word; sampled every CLK
RX_BUSY  out  1  frame in progress (state != IDLE)
FRAME_ERR  out  1  stop bit of the last delivered word was 0
OVERRUN  out  1  sticky: a word was lost

Behaviour:
- Single clock CLK. Reset R is synchronous and active-high. All state advances only on posedge CLK.
- Reset values: RXDATA=0, RX_VALID=0, RX_BUSY=0, FRAME_ERR=0, OVERRUN=0, state IDLE. The two-flop RXD synchronizer resets to 1.
- R asserted mid-frame aborts the frame; no word is delivered.
- The FSM uses only the synchronized RXD (rxs). The tick counter (width clog2(OVERSAMPLE)) advances only on cycles with RXC_EN=1.
- IDLE: on a tick with rxs=0, go to START and clear the counter. This tick is tick 0.
- START: at tick OVERSAMPLE/2 (mid-bit), check rxs.
  - rxs=1: glitch; return to IDLE, no flags.
  - rxs=0: go to DATA, reset the counter and bit index.
- DATA: every OVERSAMPLE ticks, shift rxs into bit [index] of the shift register (LSB first). After bit SIZE-1 is taken, go to STOP.
- STOP: after OVERSAMPLE ticks, sample the stop bit. On that same edge:
  - RXDATA <= shift register; RX_VALID <= 1; FRAME_ERR <= ~rxs.
  - Stop=1: go to IDLE. Stop=0: go to BREAK.
- BREAK: wait for rxs=1 on a tick, then go to IDLE. This prevents re-triggering on a held-low line.
- Stop sample timing: tick 8 + 16*(SIZE+1) after tick 0 (152 for defaults). RX_VALID is visible the following cycle.
- Handshake:
  - RX_VALID stays 1 until a CLK edge with RX_ACK=1, which clears it.
  - RX_ACK while RX_VALID=0 is ignored.
  - RXDATA and FRAME_ERR stay stable while RX_VALID=1, unless overwritten as below.
- Delivery while RX_VALID=1:
  - RX_ACK=0 on that edge: the new word overwrites RXDATA, RX_VALID stays 1, OVERRUN <= 1.
  - RX_ACK=1 on that edge: the new word is loaded, RX_VALID stays 1, no overrun.
- OVERRUN clears only on R.
- RXC_EN=0 freezes the counters; synchronizer flops still clock every cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A parity bit sits between the last data bit and stop, sampled like a data bit. The stop sample moves to tick 8 + 16*(SIZE+2).
  - Adds parameter PARITY_ODD (default 0 = even) and output PARITY_ERR (1 bit, reset 0).
  - PARITY_ERR is updated alongside FRAME_ERR at delivery: 1 when the XOR of data and parity bits does not equal PARITY_ODD.
- Undefined: no parity bit, no PARITY_ERR port, frame is exactly SIZE+2 bits.

Test Plan:
- Reset, RXD=1, RXC_EN every cycle for 500 cycles -> RX_VALID=0, RX_BUSY=0, all flags 0.
- Defaults, RXC_EN=1 every cycle, send 0xA5 at 16 cycles/bit; hold RX_ACK=0 -> RXDATA=0xA5, RX_VALID=1, FRAME_ERR=0. Then pulse RX_ACK for 1 cycle -> RX_VALID=0 next cycle.
- RXD low for 4 ticks, then high -> START rejects glitch, returns IDLE, RX_VALID stays 0, RX_BUSY drops.
- Send 0x3C with stop bit=0, line held low 40 bit-times, then high, then send 0x81 -> first delivery has FRAME_ERR=1, RXDATA=0x3C, no spurious frame during the low period. Second delivery has RXDATA=0x81, FRAME_ERR=0.
- Send 0x11 then 0x22 with no RX_ACK -> RXDATA=0x22, RX_VALID=1, OVERRUN=1. Repeat the second delivery with RX_ACK=1 on the stop-sample edge -> OVERRUN stays 0.
- Assert R at data bit 4 of a frame -> all outputs 0 next cycle. A following 0x7E frame is received correctly. With UART_RX_PARITY_EN and even parity, send 0x07 with parity bit 0 -> PARITY_ERR=1.
